// File: rtl/norm64_arbiter_if.sv
// rtl/norm64_arbiter_if.sv - Control and operand bus between the arbiter and the shared normaliser
interface norm64_arbiter_if;
  logic        n_rst;
  logic        n_en;
  logic        n_load;
  logic [51:0] n_A;
  logic [51:0] n_B;
  logic [10:0] n_eA;
  logic [10:0] n_eB;
  logic [52:0] n_Am;
  logic [52:0] n_Bm;
  logic [10:0] n_eAm;
  logic        n_OE;

  modport master (
    output n_rst, n_en, n_load, n_A, n_B, n_eA, n_eB,
    input  n_Am, n_Bm, n_eAm, n_OE
  );

  modport slave (
    input  n_rst, n_en, n_load, n_A, n_B, n_eA, n_eB,
    output n_Am, n_Bm, n_eAm, n_OE
  );
endinterface

// File: rtl/norm64_arbiter.sv
// rtl/norm64_arbiter.sv - Two-client round-robin arbiter sequencing jobs through a shared mantissa normaliser
module norm64_arbiter #(
  parameter int TIMEOUT = 2047
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0,
  input  logic             req1,
  input  logic [51:0]      c0_A,
  input  logic [51:0]      c0_B,
  input  logic [51:0]      c1_A,
  input  logic [51:0]      c1_B,
  input  logic [10:0]      c0_eA,
  input  logic [10:0]      c0_eB,
  input  logic [10:0]      c1_eA,
  input  logic [10:0]      c1_eB,
  output logic             gnt0,
  output logic             gnt1,
  output logic             done0,
  output logic             done1,
  output logic             err0,
  output logic             err1,
  output logic [52:0]      res_Am,
  output logic [52:0]      res_Bm,
  output logic [10:0]      res_e,
  norm64_arbiter_if.master nrm
);

  localparam logic [11:0] TMO = 12'(TIMEOUT);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD   = 3'd1,
    SETTLE = 3'd2,
    ALIGN  = 3'd3,
    DONE   = 3'd4
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic        id;
  logic        id_nxt;
  logic        last;
  logic        pick;
  logic        any_req;
  logic        timeout_hit;
  logic        en;
  logic        load;
  logic [11:0] cnt;
  logic [11:0] cnt_inc;
  logic [1:0]  gnt_d;
  logic [1:0]  done_d;
  logic [1:0]  err_d;
  logic [51:0] op_A;
  logic [51:0] op_B;
  logic [10:0] op_eA;
  logic [10:0] op_eB;

  // Round robin: on contention the client not serviced last wins.
  assign any_req     = req0 | req1;
  assign pick        = (req0 & req1) ? ~last : req1;
  assign cnt_inc     = (cnt == 12'hFFF) ? cnt : cnt + 12'd1;
  assign timeout_hit = ~nrm.n_OE & (cnt_inc >= TMO);

  assign nrm.n_rst  = ~rst;
  assign nrm.n_en   = en;
  assign nrm.n_load = load;
  assign nrm.n_A    = op_A;
  assign nrm.n_B    = op_B;
  assign nrm.n_eA   = op_eA;
  assign nrm.n_eB   = op_eB;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (any_req) state_nxt = LOAD;
      LOAD:    state_nxt = SETTLE;
      SETTLE:  state_nxt = ALIGN;
      ALIGN:   if (nrm.n_OE || timeout_hit) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    en     = 1'b0;
    load   = 1'b0;
    gnt_d  = 2'b00;
    done_d = 2'b00;
    err_d  = 2'b00;
    id_nxt = (state == IDLE) ? pick : id;
    case (state)
      LOAD: begin
        en   = 1'b1;
        load = 1'b1;
      end
      SETTLE, ALIGN: en = 1'b1;
      default: ;
    endcase
    if (state_nxt inside {LOAD, SETTLE, ALIGN}) gnt_d = id_nxt ? 2'b10 : 2'b01;
    if (state == ALIGN && nrm.n_OE) done_d = id ? 2'b10 : 2'b01;
    if (state == ALIGN && timeout_hit) err_d = id ? 2'b10 : 2'b01;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      gnt0  <= 1'b0;
      gnt1  <= 1'b0;
      done0 <= 1'b0;
      done1 <= 1'b0;
      err0  <= 1'b0;
      err1  <= 1'b0;
    end else begin
      gnt0  <= gnt_d[0];
      gnt1  <= gnt_d[1];
      done0 <= done_d[0];
      done1 <= done_d[1];
      err0  <= err_d[0];
      err1  <= err_d[1];
    end
  end

  // Operands are latched at arbitration so they are stable for the whole LOAD cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      id     <= 1'b0;
      last   <= 1'b1;
      cnt    <= 12'd0;
      op_A   <= 52'd0;
      op_B   <= 52'd0;
      op_eA  <= 11'd0;
      op_eB  <= 11'd0;
      res_Am <= 53'd0;
      res_Bm <= 53'd0;
      res_e  <= 11'd0;
    end else begin
      if (state == IDLE && any_req) begin
        id    <= pick;
        op_A  <= pick ? c1_A  : c0_A;
        op_B  <= pick ? c1_B  : c0_B;
        op_eA <= pick ? c1_eA : c0_eA;
        op_eB <= pick ? c1_eB : c0_eB;
      end
      if (state == SETTLE) begin
        cnt <= 12'd0;
      end else if (state == ALIGN && !nrm.n_OE) begin
        cnt <= cnt_inc;
      end
      if (state == ALIGN && nrm.n_OE) begin
        res_Am <= nrm.n_Am;
        res_Bm <= nrm.n_Bm;
        res_e  <= nrm.n_eAm;
      end
      if (state == DONE) last <= id;
    end
  end

endmodule

// File: tb/tb_norm64_arbiter.sv
// tb/tb_norm64_arbiter.sv - Randomised self-checking bench for norm64_arbiter with a behavioural normaliser
module tb_norm64_arbiter;
  localparam int T = 4;

  logic        clk;
  logic        rst;
  logic [1:0]  req_v;
  logic [51:0] opA [2];
  logic [51:0] opB [2];
  logic [10:0] opeA [2];
  logic [10:0] opeB [2];
  logic        gnt0, gnt1, done0, done1, err0, err1;
  logic [52:0] res_Am, res_Bm;
  logic [10:0] res_e;

  int          tests_run = 0;
  int          tests_failed = 0;
  bit          tb_last = 1'b1;
  bit          oe_kill = 1'b0;
  logic [52:0] exp_Am = '0;
  logic [52:0] exp_Bm = '0;
  logic [10:0] exp_e = '0;

  norm64_arbiter_if nif ();

  norm64_arbiter #(.TIMEOUT(T)) dut (
    .clk    (clk),
    .rst    (rst),
    .req0   (req_v[0]),
    .req1   (req_v[1]),
    .c0_A   (opA[0]),
    .c0_B   (opB[0]),
    .c1_A   (opA[1]),
    .c1_B   (opB[1]),
    .c0_eA  (opeA[0]),
    .c0_eB  (opeB[0]),
    .c1_eA  (opeA[1]),
    .c1_eB  (opeB[1]),
    .gnt0   (gnt0),
    .gnt1   (gnt1),
    .done0  (done0),
    .done1  (done1),
    .err0   (err0),
    .err1   (err1),
    .res_Am (res_Am),
    .res_Bm (res_Bm),
    .res_e  (res_e),
    .nrm    (nif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Normaliser: shifts the smaller-exponent mantissa one place per enabled cycle; OE is one cycle late.
  logic [52:0] ma, mb;
  logic [10:0] xa, xb;
  logic        oe;
  always @(posedge clk or posedge nif.n_rst) begin
    if (nif.n_rst) begin
      ma <= '0; mb <= '0; xa <= '0; xb <= '0; oe <= 1'b0;
    end else if (nif.n_load) begin
      ma <= {1'b1, nif.n_A}; mb <= {1'b1, nif.n_B};
      xa <= nif.n_eA; xb <= nif.n_eB; oe <= 1'b0;
    end else if (nif.n_en) begin
      oe <= (xa == xb) && !oe_kill;
      if (xa < xb) begin
        ma <= ma >> 1; xa <= xa + 11'd1;
      end else if (xb < xa) begin
        mb <= mb >> 1; xb <= xb + 11'd1;
      end
    end else begin
      oe <= 1'b0;
    end
  end
  assign nif.n_Am  = ma;
  assign nif.n_Bm  = mb;
  assign nif.n_eAm = xa + 11'd1023;
  assign nif.n_OE  = oe;

  task automatic set_ops(input int c, input int d);
    logic [63:0] r;
    int base;
    r = {$urandom, $urandom}; opA[c] = r[51:0];
    r = {$urandom, $urandom}; opB[c] = r[51:0];
    base = $urandom_range(2000, 10);
    if ($urandom % 2 == 0) begin
      opeA[c] = 11'(base + d); opeB[c] = 11'(base);
    end else begin
      opeA[c] = 11'(base); opeB[c] = 11'(base + d);
    end
  endtask

  // Runs one job from an IDLE negedge through the IDLE cycle after its pulse.
  task automatic run_job(input bit drop);
    int w, d, endc;
    bit is_err;
    logic [7:0] expv, got;
    logic [52:0] a1, b1;
    logic [10:0] emax;
    w = (req_v == 2'b11) ? int'(!tb_last) : (req_v[1] ? 1 : 0);
    d = int'(opeA[w]) - int'(opeB[w]);
    if (d < 0) d = -d;
    is_err = oe_kill || (d >= T);
    endc = is_err ? 2 + T : 3 + d;
    for (int k = 0; k <= endc + 1; k++) begin
      @(negedge clk);
      expv = 8'd0;
      if (k < endc) begin
        expv[7] = 1'b1;
        expv[6] = (k == 0);
        expv[4 + w] = 1'b1;
      end
      if (k == endc) begin
        if (is_err) expv[w] = 1'b1;
        else expv[2 + w] = 1'b1;
      end
      got = {nif.n_en, nif.n_load, gnt1, gnt0, done1, done0, err1, err0};
      tests_run++;
      if (got !== expv) begin
        tests_failed++;
        $display("FAIL job_ctl client=%0d d=%0d k=%0d got=%b exp=%b", w, d, k, got, expv);
      end
      if (k == 0) begin
        tests_run++;
        if ({nif.n_A, nif.n_B, nif.n_eA, nif.n_eB} !== {opA[w], opB[w], opeA[w], opeB[w]}) begin
          tests_failed++;
          $display("FAIL operand_mux client=%0d got=%h/%h/%0d/%0d exp=%h/%h/%0d/%0d", w,
                   nif.n_A, nif.n_B, nif.n_eA, nif.n_eB, opA[w], opB[w], opeA[w], opeB[w]);
        end
        if (drop) req_v[w] = 1'b0;
      end
    end
    if (!is_err) begin
      a1 = {1'b1, opA[w]};
      b1 = {1'b1, opB[w]};
      if (opeA[w] < opeB[w]) begin
        a1 = a1 >> d; emax = opeB[w];
      end else begin
        b1 = b1 >> d; emax = opeA[w];
      end
      exp_Am = a1; exp_Bm = b1; exp_e = emax + 11'd1023;
    end
    tests_run++;
    if ({res_Am, res_Bm, res_e} !== {exp_Am, exp_Bm, exp_e}) begin
      tests_failed++;
      $display("FAIL result client=%0d err=%0b got=%h/%h/%0d exp=%h/%h/%0d", w, is_err,
               res_Am, res_Bm, res_e, exp_Am, exp_Bm, exp_e);
    end
    tb_last = w[0];
    req_v[w] = 1'b0;
  endtask

  task automatic check_zero(input string name);
    tests_run++;
    if ({gnt0, gnt1, done0, done1, err0, err1, nif.n_en, nif.n_load, nif.n_rst} !== 9'b0_0000_0001 ||
        {res_Am, res_Bm, res_e, nif.n_A, nif.n_B, nif.n_eA, nif.n_eB} !== '0) begin
      tests_failed++;
      $display("FAIL %s got ctl=%b n_rst=%b res=%h/%h/%0d ops=%h/%h exp all zero with n_rst=1", name,
               {gnt0, gnt1, done0, done1, err0, err1, nif.n_en, nif.n_load}, nif.n_rst,
               res_Am, res_Bm, res_e, nif.n_A, nif.n_B);
    end
  endtask

  task automatic test_reset();
    req_v = 2'b00;
    for (int c = 0; c < 2; c++) begin
      opA[c] = '0; opB[c] = '0; opeA[c] = '0; opeB[c] = '0;
    end
    rst = 1'b1;
    #2 rst = 1'b0;
    #1 check_zero("reset_async");
    repeat (3) @(negedge clk);
    check_zero("reset_held");
    rst = 1'b1;
    @(negedge clk);
    tests_run++;
    if ({nif.n_rst, gnt0, gnt1, nif.n_en} !== 4'b0000) begin
      tests_failed++;
      $display("FAIL reset_release got n_rst/gnt0/gnt1/n_en=%b exp=0000", {nif.n_rst, gnt0, gnt1, nif.n_en});
    end
  endtask

  task automatic test_directed();
    set_ops(0, 0); opeA[0] = 11'd5; opeB[0] = 11'd5;
    req_v = 2'b01;
    run_job(1'b0);
    tests_run++;
    if (res_e !== 11'd1028) begin
      tests_failed++;
      $display("FAIL equal_exp_res_e got=%0d exp=1028", res_e);
    end
    set_ops(1, 0); opeA[1] = 11'd10; opeB[1] = 11'd7;
    req_v = 2'b10;
    run_job(1'b0);
    tests_run++;
    if (res_Bm !== ({1'b1, opB[1]} >> 3)) begin
      tests_failed++;
      $display("FAIL shift3_res_Bm got=%h exp=%h", res_Bm, {1'b1, opB[1]} >> 3);
    end
    set_ops(0, 2);
    req_v = 2'b01;
    run_job(1'b1);
  endtask

  task automatic test_timeout();
    oe_kill = 1'b1;
    set_ops(0, 0);
    req_v = 2'b01;
    run_job(1'b0);
    oe_kill = 1'b0;
    set_ops(1, T);
    req_v = 2'b10;
    run_job(1'b0);
    set_ops(0, T - 1);
    req_v = 2'b01;
    run_job(1'b0);
  endtask

  task automatic test_round_robin();
    set_ops(0, $urandom_range(3, 0));
    set_ops(1, $urandom_range(3, 0));
    req_v = 2'b11;
    for (int i = 0; i < 4; i++) begin
      run_job(1'b0);
      if (i < 3) begin
        set_ops(int'(tb_last), $urandom_range(3, 0));
        req_v[tb_last] = 1'b1;
      end
    end
    run_job(1'b0);
  endtask

  task automatic test_random();
    for (int i = 0; i < 24; i++) begin
      for (int c = 0; c < 2; c++) begin
        if (!req_v[c] && ($urandom % 2 == 0)) begin
          set_ops(c, $urandom_range(6, 0));
          req_v[c] = 1'b1;
        end
      end
      if (req_v == 2'b00) begin
        set_ops(i % 2, $urandom_range(6, 0));
        req_v[i % 2] = 1'b1;
      end
      oe_kill = ($urandom % 8 == 0);
      run_job($urandom % 4 == 0);
      oe_kill = 1'b0;
    end
    while (req_v != 2'b00) run_job(1'b0);
  endtask

  task automatic test_reset_mid_job();
    set_ops(0, 3);
    req_v = 2'b01;
    repeat (4) @(negedge clk);
    tests_run++;
    if ({gnt0, nif.n_en, nif.n_load} !== 3'b110) begin
      tests_failed++;
      $display("FAIL mid_job_align got gnt0/n_en/n_load=%b exp=110", {gnt0, nif.n_en, nif.n_load});
    end
    #2 rst = 1'b0;
    #1 check_zero("reset_mid_job");
    exp_Am = '0; exp_Bm = '0; exp_e = '0; tb_last = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      tests_run++;
      if ({done0, done1, err0, err1, gnt0, gnt1} !== 6'b0) begin
        tests_failed++;
        $display("FAIL reset_no_pulse k=%0d got=%b exp=000000", k, {done0, done1, err0, err1, gnt0, gnt1});
      end
    end
    set_ops(1, 1);
    req_v = 2'b11;
    rst = 1'b1;
    run_job(1'b0);
    run_job(1'b0);
  endtask

  initial begin
    req_v = 2'b00;
    rst = 1'b1;
    test_reset();
    test_directed();
    test_timeout();
    test_round_robin();
    test_random();
    test_reset_mid_job();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/norm64_arbiter.md
NORM64_ARBITER -- requirements
Module: norm64_arbiter

Interface
REQ-001 Parameter TIMEOUT, default 2047: the maximum number of ALIGN cycles without n_OE before the block aborts a job.
REQ-002 clk  in  1  rising-edge clock.
REQ-003 rst  in  1  reset, asynchronous and active-low.
REQ-004 req0, req1  in  1 each  client request level; the client holds it and its operands stable until its done or err pulse.
REQ-005 c0_A, c0_B, c1_A, c1_B  in  52 each  client mantissas (hidden bit excluded).
REQ-006 c0_eA, c0_eB, c1_eA, c1_eB  in  11 each  client exponents.
REQ-007 gnt0, gnt1  out  1 each  client currently being serviced.
REQ-008 done0, done1  out  1 each  one-cycle pulse: result valid for that client.
REQ-009 err0, err1  out  1 each  one-cycle pulse: job aborted on timeout.
REQ-010 res_Am, res_Bm  out  53 each  captured aligned mantissas.
REQ-011 res_e  out  11  captured common exponent.
REQ-012 n_rst, n_en, n_load  out  1 each  normaliser control signals.
REQ-013 n_A, n_B  out  52 each;  n_eA, n_eB  out  11 each  normaliser operands.
REQ-014 n_Am, n_Bm  in  53 each;  n_eAm  in  11;  n_OE  in  1  normaliser results.

Function
REQ-015 n_rst SHALL equal the inverse of rst.
REQ-016 The FSM SHALL have the states IDLE, LOAD, SETTLE, ALIGN and DONE, with the one-hot gnt/done/err outputs registered.
REQ-017 IDLE: if any req is high at an edge, the FSM SHALL select a client, latch the client id, go to LOAD and assert the matching gnt from that edge.
REQ-018 Arbitration SHALL be round-robin: with both requests high, the client not serviced last wins; after reset, client 0 wins.
REQ-019 LOAD (1 cycle): n_en=1, n_load=1, and n_A/n_B/n_eA/n_eB SHALL be muxed from the selected client; next state SETTLE.
REQ-020 SETTLE (1 cycle): n_en=1, n_load=0, n_OE ignored (stale) and the timeout counter cleared; next state ALIGN.
REQ-021 ALIGN: n_en=1; if n_OE=1, capture n_Am, n_Bm and n_eAm into res_* and go to DONE with done(id) pulsed; else increment the counter, and when the counter reaches TIMEOUT go to DONE with err(id) pulsed and res_* unchanged.
REQ-022 DONE (1 cycle): gnt deasserts, the last-serviced pointer becomes id, and the next state is IDLE; the following arbitration SHALL occur no earlier than IDLE.
REQ-023 Outside LOAD, SETTLE and ALIGN: n_en=0 and n_load=0; the operand outputs hold their last value.
REQ-024 Timing: with req sampled at edge E0 and |eA-eB|=d, the done pulse SHALL occupy the cycle between E(3+d) and E(4+d).
REQ-025 Deasserting req while granted SHALL NOT abort the job; the job completes and pulses normally.
REQ-026 The timeout counter SHALL be 12 bits wide and saturate, never wrapping.
REQ-027 res_* SHALL hold between jobs.

Reset
REQ-028 With rst=0, asynchronously: state=IDLE; gnt*, done*, err*, n_en and n_load = 0; n_rst=1; res_*, the counter and the operand outputs = 0; the pointer favours client 0.
REQ-029 Reset asserted mid-job SHALL abandon the job with no done or err pulse; after release, the FSM returns to IDLE and re-arbitrates on the next edge.

Verification (behavioural normaliser model attached)
REQ-030 Equal exponents, req0, eA=eB=5 -> gnt0 for 3 cycles, done0 in cycle E3, res_e = 5+1023 (mod 2048).
REQ-031 req1, eA=10, eB=7 (d=3) -> done1 in cycle E6, res_Bm equals {1,B} shifted right by 3.
REQ-032 req0 and req1 asserted together, continuously -> grants alternate 0,1,0,1; each done is followed by at least one IDLE cycle.
REQ-033 TIMEOUT=4, model never raises n_OE -> err0 pulses after 4 ALIGN cycles, done0 stays 0, and res_* is unchanged.
REQ-034 Reset pulsed during ALIGN -> outputs zero immediately, no done pulse, n_rst=1 during the pulse, and a fresh grant occurs after release.
